display_mux_ctrl: RTL and testbench

DISPLAY_MUX_CTRL -- requirements
Module: display_mux_ctrl

---
 rtl/display_pkg.sv | 20 ++
 rtl/display_mux_ctrl_if.sv | 12 +
 rtl/tick_gen.sv | 25 ++
 rtl/display_mux_ctrl.sv | 102 ++++++++++
 tb/tb_display_mux_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and defaults for the two-digit multiplexed display controller.
package display_pkg;

  typedef enum logic [1:0] {
    BLANK0,
    SHOW0,
    BLANK1,
    SHOW1
  } disp_state_t;

  localparam int DEF_CLK_DIV     = 2400;
  localparam int DEF_SHOW_TICKS  = 8;
  localparam int DEF_BLANK_TICKS = 1;

  // A counter reaching n-1 needs $clog2(n) bits, but never fewer than one.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/display_mux_ctrl_if.sv
// Digit-pair update handshake between a producer and the display controller.
interface display_mux_ctrl_if;

  logic       upd_valid;
  logic [3:0] upd_d1;
  logic [3:0] upd_d2;
  logic       upd_ready;

  modport master (output upd_valid, output upd_d1, output upd_d2, input upd_ready);
  modport slave  (input upd_valid, input upd_d1, input upd_d2, output upd_ready);

endinterface

// File: rtl/tick_gen.sv
// Refresh prescaler: one-cycle tick every CLK_DIV clocks.
module tick_gen import display_pkg::*; #(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int             W    = cnt_width(CLK_DIV);
  localparam logic [W-1:0]   LAST = W'(CLK_DIV - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset || count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/display_mux_ctrl.sv
// Two-digit display multiplexer with blanking dead time and a frame-synchronous
// update buffer so the shown digits only change between frames.
module display_mux_ctrl import display_pkg::*; #(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int SHOW_TICKS  = DEF_SHOW_TICKS,
  parameter int BLANK_TICKS = DEF_BLANK_TICKS
) (
  input  logic                     clk,
  input  logic                     reset,
  display_mux_ctrl_if.slave        upd,
  output logic [3:0]               s1,
  output logic [3:0]               s2,
  output logic                     sel,
  output logic [1:0]               an,
  output logic                     frame_done
);

  localparam int              DMAX       = (SHOW_TICKS > BLANK_TICKS) ? SHOW_TICKS : BLANK_TICKS;
  localparam int              DW         = cnt_width(DMAX);
  localparam logic [DW-1:0]   SHOW_LAST  = DW'(SHOW_TICKS - 1);
  localparam logic [DW-1:0]   BLANK_LAST = DW'(BLANK_TICKS - 1);

  disp_state_t   state, state_n;
  logic [DW-1:0] dwell, dwell_n, dwell_last;
  logic          tick, advance, accept, commit;
  logic          pend_full;
  logic [3:0]    pend_d1, pend_d2;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BLANK0;
      dwell <= '0;
    end else begin
      state <= state_n;
      dwell <= dwell_n;
    end
  end

  always_comb begin
    state_n    = state;
    dwell_n    = dwell;
    advance    = 1'b0;
    dwell_last = (state == SHOW0 || state == SHOW1) ? SHOW_LAST : BLANK_LAST;
    if (tick) begin
      if (dwell == dwell_last) begin
        advance = 1'b1;
        dwell_n = '0;
        case (state)
          BLANK0:  state_n = SHOW0;
          SHOW0:   state_n = BLANK1;
          BLANK1:  state_n = SHOW1;
          SHOW1:   state_n = BLANK0;
          default: state_n = BLANK0;
        endcase
      end else begin
        dwell_n = dwell + 1'b1;
      end
    end
  end

  assign accept = upd.upd_valid && upd.upd_ready;
  assign commit = advance && (state == SHOW1) && pend_full;

  // Outputs decode the next state so they land together with the state change.
  // upd_ready lags the buffer emptying by one cycle, so the commit cycle itself
  // still refuses a new offer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      an            <= 2'b11;
      sel           <= 1'b0;
      s1            <= 4'h0;
      s2            <= 4'h0;
      frame_done    <= 1'b0;
      pend_full     <= 1'b0;
      pend_d1       <= 4'h0;
      pend_d2       <= 4'h0;
      upd.upd_ready <= 1'b1;
    end else begin
      an            <= (state_n == SHOW0) ? 2'b10 : (state_n == SHOW1) ? 2'b01 : 2'b11;
      sel           <= (state_n == BLANK1) || (state_n == SHOW1);
      frame_done    <= advance && (state == SHOW1);
      upd.upd_ready <= !(pend_full || accept);
      if (accept) begin
        pend_d1   <= upd.upd_d1;
        pend_d2   <= upd.upd_d2;
        pend_full <= 1'b1;
      end
      if (commit) begin
        s1        <= pend_d1;
        s2        <= pend_d2;
        pend_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Scoreboard bench for display_mux_ctrl: frame timing from phase arithmetic,
// accepted digit pairs queued with the frame_done cycle at which they must appear.
module tb_display_mux_ctrl;

  localparam int CLK_DIV     = 4;
  localparam int SHOW_TICKS  = 2;
  localparam int BLANK_TICKS = 1;
  localparam int PERIOD      = 2 * (SHOW_TICKS + BLANK_TICKS) * CLK_DIV;
  localparam int SHOW0_AT    = BLANK_TICKS * CLK_DIV;
  localparam int BLANK1_AT   = (BLANK_TICKS + SHOW_TICKS) * CLK_DIV;
  localparam int SHOW1_AT    = (2 * BLANK_TICKS + SHOW_TICKS) * CLK_DIV;

  typedef struct {
    int         acc;
    int         due;
    logic [3:0] d1;
    logic [3:0] d2;
  } upd_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] s1, s2;
  logic       sel;
  logic [1:0] an;
  logic       frame_done;

  display_mux_ctrl_if upd_bus ();

  display_mux_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .SHOW_TICKS (SHOW_TICKS),
    .BLANK_TICKS(BLANK_TICKS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .upd       (upd_bus),
    .s1        (s1),
    .s2        (s2),
    .sel       (sel),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         running = 1'b0;
  bit         rst_armed = 1'b0;
  bit         exp_ready = 1'b1;
  bit         pend_valid = 1'b0;
  int         pend_acc = 0;
  int         pend_due = 0;
  logic [3:0] shown1 = 4'h0;
  logic [3:0] shown2 = 4'h0;
  upd_t       sb[$];
  int         mon_phase;
  bit         found;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, actual, expected);
    end
  endtask

  // An offer takes effect at the end of the first frame whose last tick follows it.
  function automatic int dueFrame(input int a);
    return (a % PERIOD == PERIOD - 1) ? (a / PERIOD + 2) * PERIOD : (a / PERIOD + 1) * PERIOD;
  endfunction

  function automatic logic [1:0] expAn(input int p);
    if (p < SHOW0_AT)  return 2'b11;
    if (p < BLANK1_AT) return 2'b10;
    if (p < SHOW1_AT)  return 2'b11;
    return 2'b01;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
    if (reset) begin
      cyc++;
    end else begin
      running   = 1'b0;
      rst_armed = 1'b1;
    end
  endtask

  task automatic releaseReset();
    reset      = 1'b1;
    cyc        = 0;
    running    = 1'b1;
    rst_armed  = 1'b0;
    pend_valid = 1'b0;
    exp_ready  = 1'b1;
    shown1     = 4'h0;
    shown2     = 4'h0;
    sb.delete();
  endtask

  task automatic applyStimulus(input bit want, input logic [3:0] d1, input logic [3:0] d2);
    if (pend_valid && cyc > pend_due) pend_valid = 1'b0;
    exp_ready = !(pend_valid && cyc > pend_acc && cyc <= pend_due);
    upd_bus.upd_valid = want;
    upd_bus.upd_d1    = d1;
    upd_bus.upd_d2    = d2;
    if (want && exp_ready) begin
      pend_valid = 1'b1;
      pend_acc   = cyc;
      pend_due   = dueFrame(cyc);
      sb.push_back('{acc: cyc, due: pend_due, d1: d1, d2: d2});
    end
  endtask

  task automatic driveDirected();
    case (cyc)
      6:       applyStimulus(1'b1, 4'h3, 4'hA);
      10:      applyStimulus(1'b1, 4'h5, 4'h5);
      24:      applyStimulus(1'b1, 4'h7, 4'h1);
      25:      applyStimulus(1'b1, 4'h7, 4'h1);
      default: applyStimulus(1'b0, 4'h0, 4'h0);
    endcase
  endtask

  always @(negedge clk) begin
    if (running) begin
      mon_phase = cyc % PERIOD;
      checkOutput("an", 8'(an), 8'(expAn(mon_phase)));
      checkOutput("sel", 8'(sel), 8'(mon_phase >= BLANK1_AT));
      checkOutput("frame_done", 8'(frame_done), 8'(mon_phase == 0 && cyc > 0));
      checkOutput("upd_ready", 8'(upd_bus.upd_ready), 8'(exp_ready));
      if (sb.size() > 0 && sb[0].due < cyc) begin
        errors++;
        checks++;
        $display("[TB] FAIL commit_late cycle %0d: got none expected %0h/%0h at cycle %0d",
                 cyc, sb[0].d1, sb[0].d2, sb[0].due);
        shown1 = sb[0].d1;
        shown2 = sb[0].d2;
        void'(sb.pop_front());
      end else if (frame_done && sb.size() > 0 && sb[0].due == cyc) begin
        shown1 = sb[0].d1;
        shown2 = sb[0].d2;
        void'(sb.pop_front());
      end
      checkOutput("s1", 8'(s1), 8'(shown1));
      checkOutput("s2", 8'(s2), 8'(shown2));
    end else if (rst_armed) begin
      checkOutput("rst_an", 8'(an), 8'h03);
      checkOutput("rst_sel", 8'(sel), 8'h00);
      checkOutput("rst_s1", 8'(s1), 8'h00);
      checkOutput("rst_s2", 8'(s2), 8'h00);
      checkOutput("rst_upd_ready", 8'(upd_bus.upd_ready), 8'h01);
      checkOutput("rst_frame_done", 8'(frame_done), 8'h00);
    end
  end

  initial begin
    upd_bus.upd_valid = 1'b0;
    upd_bus.upd_d1    = 4'h0;
    upd_bus.upd_d2    = 4'h0;
    reset             = 1'b0;
    repeat (3) stepCycle();

    releaseReset();
    driveDirected();
    while (cyc < 2 * PERIOD + 4) begin
      stepCycle();
      driveDirected();
    end

    while (cyc < 16 * PERIOD) begin
      stepCycle();
      applyStimulus($urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    // Hit reset while a pair is pending and the controller sits in SHOW1.
    found = 1'b0;
    for (int i = 0; i < 8 * PERIOD && !found; i++) begin
      stepCycle();
      if (pend_valid && (cyc % PERIOD) >= SHOW1_AT && cyc < pend_due) begin
        applyStimulus(1'b0, 4'h0, 4'h0);
        reset = 1'b0;
        found = 1'b1;
      end else begin
        applyStimulus(1'b1, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
      end
    end
    if (!found) begin
      errors++;
      checks++;
      $display("[TB] FAIL show1_reset_wait cycle %0d: got no pending SHOW1 window expected one", cyc);
    end else begin
      stepCycle();
      stepCycle();
      releaseReset();
      applyStimulus(1'b0, 4'h0, 4'h0);
      while (cyc < 2 * PERIOD + 2) begin
        stepCycle();
        applyStimulus(1'b0, 4'h0, 4'h0);
      end
    end

    @(negedge clk);
    #1;
    running   = 1'b0;
    rst_armed = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
